// File: rtl/hazard_fwd_scoreboard_if.sv
// Interface from the ID stage to the hazard/forwarding scoreboard.
// The master is the ID stage, and the slave is the scoreboard that drives the EX operand selects.
interface hazard_fwd_scoreboard_if #(
  parameter int unsigned REG_W     = 5,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned CNT_W     = 16
);
  localparam int unsigned SW = $clog2(FWD_DEPTH + 1);

  logic             hold;
  logic             flush;
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [REG_W-1:0] id_dst;
  logic             id_regwrite;
  logic             id_memread;
  logic             stall;
  logic [SW-1:0]    fwd_a_sel;
  logic [SW-1:0]    fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output hold, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
    output id_dst, id_regwrite, id_memread,
    input  stall, fwd_a_sel, fwd_b_sel, stall_cnt
  );

  modport slave (
    input  hold, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
    input  id_dst, id_regwrite, id_memread,
    output stall, fwd_a_sel, fwd_b_sel, stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_scoreboard.sv
// Hazard and forwarding scoreboard: tracks in-flight destinations after ID, raises load-use
// stalls and registers the EX-stage operand forward selects.
module hazard_fwd_scoreboard #(
  parameter int unsigned REG_W     = 5,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned CNT_W     = 16
) (
  input logic                    clk,
  input logic                    rst,
  hazard_fwd_scoreboard_if.slave bus
);
  localparam int unsigned SW   = $clog2(FWD_DEPTH + 1);
  localparam int unsigned RdyW = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;

  // rdy counts the remaining cycles before a load result becomes forwardable.
  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] dst;
    logic             wr;
    logic [RdyW-1:0]  rdy;
  } slot_t;

  slot_t            slot_q [FWD_DEPTH];
  slot_t            slot_d [FWD_DEPTH];
  logic [SW-1:0]    fwd_a_q, fwd_a_d;
  logic [SW-1:0]    fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    hit_a, hit_b;
  logic             busy_a, busy_b;
  logic             stall;
  logic             issue;

  function automatic logic slot_match(slot_t s, logic [REG_W-1:0] r);
    return s.vld && s.wr && (s.dst == r) && (r != '0);
  endfunction

  // Walk from the oldest slot to the youngest so that the youngest producer wins.
  always_comb begin
    hit_a  = '0;
    hit_b  = '0;
    busy_a = 1'b0;
    busy_b = 1'b0;
    for (int k = int'(FWD_DEPTH) - 1; k >= 0; k--) begin
      if (slot_match(slot_q[k], bus.id_rs)) begin
        hit_a  = SW'(k + 1);
        busy_a = (slot_q[k].rdy != '0);
      end
      if (slot_match(slot_q[k], bus.id_rt)) begin
        hit_b  = SW'(k + 1);
        busy_b = (slot_q[k].rdy != '0);
      end
    end
  end

  assign stall = rst && bus.id_valid && !bus.flush &&
                 ((bus.id_use_rs && busy_a) || (bus.id_use_rt && busy_b));
  assign issue = bus.id_valid && !stall && !bus.flush;

  always_comb begin
    slot_d  = slot_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    cnt_d   = cnt_q;
    if (!bus.hold) begin
      if (issue) begin
        slot_d[0].vld = 1'b1;
        slot_d[0].dst = bus.id_dst;
        slot_d[0].wr  = bus.id_regwrite;
        slot_d[0].rdy = bus.id_memread ? RdyW'(LOAD_LAT) : '0;
      end else begin
        slot_d[0] = '0;
      end
      for (int k = 1; k < int'(FWD_DEPTH); k++) begin
        slot_d[k] = slot_q[k-1];
        if (slot_q[k-1].rdy != '0) begin
          slot_d[k].rdy = slot_q[k-1].rdy - RdyW'(1);
        end
        // A taken branch also kills the instruction leaving EX.
        if (bus.flush && (k == 1)) begin
          slot_d[k] = '0;
        end
      end
      fwd_a_d = (issue && bus.id_use_rs) ? hit_a : '0;
      fwd_b_d = (issue && bus.id_use_rt) ? hit_b : '0;
      if (stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < int'(FWD_DEPTH); k++) begin
        slot_q[k] <= '0;
      end
      fwd_a_q <= '0;
      fwd_b_q <= '0;
      cnt_q   <= '0;
    end else begin
      slot_q  <= slot_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.fwd_a_sel = fwd_a_q;
  assign bus.fwd_b_sel = fwd_b_q;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Scoreboard bench: two scoreboard configurations share one stimulus stream; a positional
// pipeline model predicts each cycle's outputs and a monitor compares them on the falling edge.
module tb_hazard_fwd_scoreboard;
  localparam int D0 = 2, L0 = 1, C0 = 16;
  localparam int D1 = 3, L1 = 2, C1 = 3;

  typedef struct packed {
    logic       rst, hold, flush, valid, urs, urt, regw, memrd;
    logic [4:0] rs, rt, dst;
  } stim_t;

  typedef struct {
    int cyc;
    int stall;
    int a;
    int b;
    int cnt;
  } exp_t;

  typedef struct {
    bit vld;
    int dst;
    bit wr;
    bit ld;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_fwd_scoreboard_if #(.REG_W(5), .FWD_DEPTH(D0), .CNT_W(C0)) bus0 ();
  hazard_fwd_scoreboard_if #(.REG_W(5), .FWD_DEPTH(D1), .CNT_W(C1)) bus1 ();

  hazard_fwd_scoreboard #(.REG_W(5), .FWD_DEPTH(D0), .LOAD_LAT(L0), .CNT_W(C0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  hazard_fwd_scoreboard #(.REG_W(5), .FWD_DEPTH(D1), .LOAD_LAT(L1), .CNT_W(C1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int   depth [2] = '{D0, D1};
  int   lat   [2] = '{L0, L1};
  int   cmax  [2] = '{(1 << C0) - 1, (1 << C1) - 1};
  ent_t pipe  [2][4];
  int   sel_a [2];
  int   sel_b [2];
  int   cnt   [2];
  exp_t exp_q0 [$];
  exp_t exp_q1 [$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  function automatic void check(string name, int c, int got, int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, c, got, want);
    end
  endfunction

  function automatic void model_reset(int i);
    for (int k = 0; k < 4; k++) pipe[i][k] = '{vld: 1'b0, dst: 0, wr: 1'b0, ld: 1'b0};
    sel_a[i] = 0;
    sel_b[i] = 0;
    cnt[i]   = 0;
  endfunction

  // A load in position k has been past EX for k-1 cycles; it is usable once that reaches lat.
  function automatic void lookup(int i, int r, output int hit, output bit busy);
    hit  = 0;
    busy = 1'b0;
    for (int k = 1; k <= depth[i]; k++) begin
      if (hit == 0 && pipe[i][k].vld && pipe[i][k].wr && pipe[i][k].dst == r && r != 0) begin
        hit  = k;
        busy = pipe[i][k].ld && ((k - 1) < lat[i]);
      end
    end
  endfunction

  function automatic exp_t model_step(int i, stim_t s);
    exp_t e;
    int   ha, hb;
    bit   ba, bb, st, iss;
    e.cyc = cyc;
    e.a   = sel_a[i];
    e.b   = sel_b[i];
    e.cnt = cnt[i];
    if (!s.rst) begin
      e.stall = 0;
      model_reset(i);
      return e;
    end
    lookup(i, int'(s.rs), ha, ba);
    lookup(i, int'(s.rt), hb, bb);
    st      = s.valid && !s.flush && ((s.urs && ba) || (s.urt && bb));
    e.stall = int'(st);
    if (!s.hold) begin
      iss      = s.valid && !st && !s.flush;
      sel_a[i] = (iss && s.urs) ? ha : 0;
      sel_b[i] = (iss && s.urt) ? hb : 0;
      if (st && cnt[i] < cmax[i]) cnt[i]++;
      for (int k = depth[i]; k >= 2; k--) pipe[i][k] = pipe[i][k-1];
      if (s.flush) pipe[i][2].vld = 1'b0;
      pipe[i][1] = '{vld: iss, dst: int'(s.dst), wr: s.regw, ld: s.memrd};
    end
    return e;
  endfunction

  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    cyc++;
    rst = s.rst;
    bus0.hold = s.hold;  bus1.hold = s.hold;
    bus0.flush = s.flush;  bus1.flush = s.flush;
    bus0.id_valid = s.valid;  bus1.id_valid = s.valid;
    bus0.id_rs = s.rs;  bus1.id_rs = s.rs;
    bus0.id_rt = s.rt;  bus1.id_rt = s.rt;
    bus0.id_use_rs = s.urs;  bus1.id_use_rs = s.urs;
    bus0.id_use_rt = s.urt;  bus1.id_use_rt = s.urt;
    bus0.id_dst = s.dst;  bus1.id_dst = s.dst;
    bus0.id_regwrite = s.regw;  bus1.id_regwrite = s.regw;
    bus0.id_memread = s.memrd;  bus1.id_memread = s.memrd;
    exp_q0.push_back(model_step(0, s));
    exp_q1.push_back(model_step(1, s));
  endtask

  function automatic stim_t nop();
    stim_t s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic stim_t ins(int rs, int rt, bit urs, bit urt, int dst, bit regw, bit memrd);
    stim_t s = nop();
    s.valid = 1'b1;
    s.rs    = 5'(rs);
    s.rt    = 5'(rt);
    s.urs   = urs;
    s.urt   = urt;
    s.dst   = 5'(dst);
    s.regw  = regw;
    s.memrd = memrd;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst   = ($urandom_range(0, 99) >= 2);
    s.hold  = ($urandom_range(0, 99) < 8);
    s.flush = ($urandom_range(0, 99) < 8);
    s.valid = ($urandom_range(0, 99) < 85);
    s.urs   = ($urandom_range(0, 99) < 70);
    s.urt   = ($urandom_range(0, 99) < 70);
    s.regw  = ($urandom_range(0, 99) < 70);
    s.memrd = ($urandom_range(0, 99) < 30);
    s.rs    = 5'($urandom_range(0, 7));
    s.rt    = 5'($urandom_range(0, 7));
    s.dst   = 5'($urandom_range(0, 7));
    return s;
  endfunction

  exp_t m0, m1;
  always @(negedge clk) begin
    if (exp_q0.size() > 0) begin
      m0 = exp_q0.pop_front();
      check("d0_stall", m0.cyc, int'(bus0.stall), m0.stall);
      check("d0_fwd_a", m0.cyc, int'(bus0.fwd_a_sel), m0.a);
      check("d0_fwd_b", m0.cyc, int'(bus0.fwd_b_sel), m0.b);
      check("d0_cnt", m0.cyc, int'(bus0.stall_cnt), m0.cnt);
    end
    if (exp_q1.size() > 0) begin
      m1 = exp_q1.pop_front();
      check("d1_stall", m1.cyc, int'(bus1.stall), m1.stall);
      check("d1_fwd_a", m1.cyc, int'(bus1.fwd_a_sel), m1.a);
      check("d1_fwd_b", m1.cyc, int'(bus1.fwd_b_sel), m1.b);
      check("d1_cnt", m1.cyc, int'(bus1.stall_cnt), m1.cnt);
    end
  end

  stim_t s;
  initial begin
    rst = 1'b0;
    bus0.hold = 0; bus0.flush = 0; bus0.id_valid = 0; bus0.id_rs = 0; bus0.id_rt = 0;
    bus0.id_use_rs = 0; bus0.id_use_rt = 0; bus0.id_dst = 0; bus0.id_regwrite = 0;
    bus0.id_memread = 0;
    bus1.hold = 0; bus1.flush = 0; bus1.id_valid = 0; bus1.id_rs = 0; bus1.id_rt = 0;
    bus1.id_use_rs = 0; bus1.id_use_rt = 0; bus1.id_dst = 0; bus1.id_regwrite = 0;
    bus1.id_memread = 0;
    model_reset(0);
    model_reset(1);
    s = nop(); s.rst = 1'b0;
    drive(s);
    drive(nop());
    // Back-to-back ALU dependency, then a two-apart dependency on rt.
    drive(ins(1, 2, 1, 1, 3, 1, 0));
    drive(ins(3, 1, 1, 1, 5, 1, 0));
    drive(ins(1, 2, 1, 1, 3, 1, 0));
    drive(nop());
    drive(ins(6, 3, 1, 1, 7, 1, 0));
    drive(nop());
    // Load-use on rt and on rs; the consumer repeats while stalled.
    drive(ins(1, 0, 1, 0, 4, 1, 1));
    repeat (3) drive(ins(1, 4, 1, 1, 6, 1, 0));
    drive(ins(1, 0, 1, 0, 7, 1, 1));
    repeat (3) drive(ins(7, 2, 1, 1, 6, 1, 0));
    // Youngest producer wins; r0 never forwards.
    drive(ins(1, 1, 1, 1, 2, 1, 0));
    drive(ins(1, 1, 1, 1, 2, 1, 0));
    drive(ins(2, 2, 1, 1, 5, 1, 0));
    drive(ins(1, 1, 1, 1, 0, 1, 1));
    drive(ins(0, 0, 1, 1, 5, 1, 0));
    drive(nop());
    // Flush against a load-use, hold mid-stall, reset mid-stall.
    drive(ins(1, 0, 1, 0, 4, 1, 1));
    s = ins(0, 4, 0, 1, 6, 1, 0); s.flush = 1'b1;
    drive(s);
    drive(ins(0, 4, 0, 1, 6, 1, 0));
    drive(ins(1, 0, 1, 0, 4, 1, 1));
    drive(ins(4, 0, 1, 0, 6, 1, 0));
    s = ins(4, 0, 1, 0, 6, 1, 0); s.hold = 1'b1;
    repeat (2) drive(s);
    repeat (2) drive(ins(4, 0, 1, 0, 6, 1, 0));
    drive(ins(1, 0, 1, 0, 4, 1, 1));
    drive(ins(4, 4, 1, 1, 6, 1, 0));
    s = ins(4, 4, 1, 1, 6, 1, 0); s.rst = 1'b0;
    drive(s);
    drive(ins(4, 4, 1, 1, 6, 1, 0));
    repeat (3000) drive(rand_stim());
    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d want=0", exp_q0.size() + exp_q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
